// File: rtl/rot_pkg.sv
// rot_pkg: shared sizes, angle/state encodings and the output-to-source coordinate mapping
package rot_pkg;
    localparam int ROT_DIM_LOG2 = 6;
    localparam int ROT_PIX_W    = 24;

    typedef enum logic [1:0] {ROT_0, ROT_90, ROT_180, ROT_270} angle_t;
    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    function automatic angle_t decode_angle(input logic [3:0] code);
        return code > 4'd3 ? ROT_0 : angle_t'(code[1:0]);
    endfunction

    // Bitwise inversion gives DIM-1-x, so every term stays modulo DIM
    function automatic logic [2*ROT_DIM_LOG2-1:0] src_addr(
        input logic [ROT_DIM_LOG2-1:0] r,
        input logic [ROT_DIM_LOG2-1:0] c,
        input angle_t                  ang,
        input logic                    mir
    );
        logic [ROT_DIM_LOG2-1:0] cc, sr, sc;
        cc = mir ? ~c : c;
        sr = ang == ROT_90 ? ~cc : ang == ROT_180 ? ~r  : ang == ROT_270 ? cc : r;
        sc = ang == ROT_90 ? r   : ang == ROT_180 ? ~cc : ang == ROT_270 ? ~r : cc;
        return {sr, sc};
    endfunction
endpackage

// File: rtl/rot_skid_buf.sv
// rot_skid_buf: 2-entry valid/ready buffer for read results; credit = free entries
module rot_skid_buf #(
    parameter int W = 37
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic [1:0]   credit
);
    logic [W-1:0] mem [2];
    logic         rp, wp;
    logic [1:0]   cnt;
    logic         pop;

    assign valid  = cnt != 2'd0;
    assign dout   = mem[rp];
    assign credit = 2'd2 - cnt;
    assign pop    = valid & ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rp     <= 1'b0;
            wp     <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) mem[wp] <= din;
            if (push) wp <= ~wp;
            if (pop) rp <= ~rp;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/rot_frame_sequencer.sv
// rot_frame_sequencer: buffers one frame, then streams it back rotated by the latched angle.
// Optional ROT_MIRROR_EN adds i_mirror for a horizontal mirror after rotation.
module rot_frame_sequencer
    import rot_pkg::*;
#(
    parameter int DIM_LOG2 = ROT_DIM_LOG2,
    parameter int PIX_W    = ROT_PIX_W
) (
    input  logic                  axi_clk,
    input  logic                  reset,
    input  logic [3:0]            aci,
`ifdef ROT_MIRROR_EN
    input  logic                  i_mirror,
`endif
    input  logic                  i_rgb_data_valid,
    input  logic [PIX_W-1:0]      i_rgb_data,
    output logic                  o_in_ready,
    output logic                  buf_we,
    output logic [2*DIM_LOG2-1:0] buf_waddr,
    output logic [PIX_W-1:0]      buf_wdata,
    output logic                  buf_re,
    output logic [2*DIM_LOG2-1:0] buf_raddr,
    input  logic [PIX_W-1:0]      buf_rdata,
    output logic                  o_rgb_data_valid,
    output logic [PIX_W-1:0]      o_rgb_data,
    input  logic                  i_out_ready,
    output logic                  line_flag,
    output logic [DIM_LOG2-1:0]   a,
    output logic [DIM_LOG2-1:0]   b,
    output logic                  frame_done,
    output logic                  o_overrun
);
    localparam int AW = 2*DIM_LOG2;
    localparam int SW = PIX_W + AW + 1;

    state_t                state;
    angle_t                ang;
    logic                  mir, mir_in, accept, pop, last_out, infl, rd_done;
    logic [AW-1:0]         wcnt, rcnt;
    logic [DIM_LOG2-1:0]   rrow, rcol, infl_r, infl_c;
    logic [SW-1:0]         skid_dout;
    logic [1:0]            credit;

`ifdef ROT_MIRROR_EN
    assign mir_in = i_mirror;
`else
    assign mir_in = 1'b0;
`endif

    assign o_in_ready = state != DRAIN;
    assign accept     = i_rgb_data_valid & o_in_ready;
    assign buf_we     = accept;
    assign buf_waddr  = wcnt;
    assign buf_wdata  = i_rgb_data;
    assign rrow       = rcnt[AW-1:DIM_LOG2];
    assign rcol       = rcnt[DIM_LOG2-1:0];
    assign buf_raddr  = src_addr(rrow, rcol, ang, mir);
    assign pop        = o_rgb_data_valid & i_out_ready;
    assign last_out   = &a & &b;
    // A read needs a free skid slot when its data lands, after this cycle's pop
    assign buf_re     = state == DRAIN && !rd_done &&
                        ({2'b0, infl} < {1'b0, credit} + {2'b0, pop});

    assign o_rgb_data = skid_dout[SW-1 -: PIX_W];
    assign a          = skid_dout[AW:DIM_LOG2+1];
    assign b          = skid_dout[DIM_LOG2:1];
    assign line_flag  = o_rgb_data_valid & skid_dout[0];

    rot_skid_buf #(.W(SW)) u_skid (
        .clk    (axi_clk),
        .rst    (reset),
        .push   (infl),
        .din    ({buf_rdata, infl_r, infl_c, &infl_c}),
        .ready  (i_out_ready),
        .valid  (o_rgb_data_valid),
        .dout   (skid_dout),
        .credit (credit)
    );

    always_ff @(posedge axi_clk) begin
        if (reset) begin
            state      <= IDLE;
            ang        <= ROT_0;
            mir        <= 1'b0;
            wcnt       <= '0;
            rcnt       <= '0;
            rd_done    <= 1'b0;
            infl       <= 1'b0;
            infl_r     <= '0;
            infl_c     <= '0;
            frame_done <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            infl       <= buf_re;
            frame_done <= pop & last_out;
            if (i_rgb_data_valid & !o_in_ready) o_overrun <= 1'b1;
            if (accept) wcnt <= wcnt + 1'b1;
            if (buf_re) begin
                rcnt    <= rcnt + 1'b1;
                infl_r  <= rrow;
                infl_c  <= rcol;
                rd_done <= &rcnt;
            end
            if (state == IDLE && accept) begin
                state <= FILL;
                ang   <= decode_angle(aci);
                mir   <= mir_in;
            end
            if (state == FILL && accept && &wcnt) state <= DRAIN;
            if (state == DRAIN && pop && last_out) begin
                state   <= IDLE;
                rd_done <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rot_frame_sequencer.sv
// tb_rot_frame_sequencer: scoreboard bench for the frame rotation sequencer
module tb_rot_frame_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  aci = '0;
    logic        mirror = 1'b0;
    logic        i_rgb_data_valid = 1'b0;
    logic [23:0] i_rgb_data = '0;
    logic        o_in_ready, buf_we, buf_re, o_rgb_data_valid, line_flag, frame_done, o_overrun;
    logic [11:0] buf_waddr, buf_raddr;
    logic [23:0] buf_wdata, buf_rdata, o_rgb_data;
    logic        i_out_ready = 1'b1;
    logic [5:0]  a, b;

    logic [23:0] mem [4096];
    logic [23:0] got_pix [4096];
    logic [36:0] sb [$];
    logic [36:0] held;
    int          checks = 0, failures = 0, pending = 0, lat = 0;
    bit          rnd_ready = 0, stall_hold = 0, done_pend = 0, done_seen = 0, measuring = 0, prev_ready = 1;

    always #5 clk = ~clk;

    rot_frame_sequencer dut (
        .axi_clk(clk), .reset(reset), .aci(aci),
`ifdef ROT_MIRROR_EN
        .i_mirror(mirror),
`endif
        .i_rgb_data_valid(i_rgb_data_valid), .i_rgb_data(i_rgb_data), .o_in_ready(o_in_ready),
        .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
        .buf_re(buf_re), .buf_raddr(buf_raddr), .buf_rdata(buf_rdata),
        .o_rgb_data_valid(o_rgb_data_valid), .o_rgb_data(o_rgb_data), .i_out_ready(i_out_ready),
        .line_flag(line_flag), .a(a), .b(b), .frame_done(frame_done), .o_overrun(o_overrun)
    );

    always @(posedge clk) begin
        if (buf_we) mem[buf_waddr] <= buf_wdata;
        if (buf_re) buf_rdata <= mem[buf_raddr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int src_of(input int code, input bit m, input int r, input int c);
        int cc, sr, sc;
        cc = m ? 63 - c : c;
        case (code)
            1: begin sr = 63 - cc; sc = r; end
            2: begin sr = 63 - r; sc = 63 - cc; end
            3: begin sr = cc; sc = 63 - r; end
            default: begin sr = r; sc = cc; end
        endcase
        return sr * 64 + sc;
    endfunction

    initial forever begin
        @(posedge clk); #1;
        i_out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (reset) begin
            pending = 0; stall_hold = 0; done_pend = 0; measuring = 0; prev_ready = 1;
        end else begin
            if (done_pend || frame_done) check("frame_done", frame_done, done_pend);
            if (frame_done) done_seen = 1;
            done_pend = 0;
            if (prev_ready && !o_in_ready) begin measuring = 1; lat = 0; end
            prev_ready = o_in_ready;
            if (measuring && o_rgb_data_valid) begin
                check("first_valid_lat", lat, 2);
                measuring = 0;
            end else if (measuring) lat++;
            if (stall_hold && o_rgb_data_valid)
                check("stall_stable", {o_rgb_data, a, b, line_flag}, held);
            stall_hold = o_rgb_data_valid && !i_out_ready;
            held = {o_rgb_data, a, b, line_flag};
            if (buf_re)
                check("re_credit", (pending + 1 - int'(o_rgb_data_valid && i_out_ready)) <= 2, 1);
            pending += int'(buf_re) - int'(o_rgb_data_valid && i_out_ready);
            if (o_rgb_data_valid && i_out_ready) begin
                if (sb.size() == 0) check("unexpected_out", 1, 0);
                else begin
                    logic [36:0] e;
                    e = sb.pop_front();
                    check("pix", o_rgb_data, e[36:13]);
                    check("coord", {a, b, line_flag}, e[12:0]);
                    got_pix[{a, b}] = o_rgb_data;
                    done_pend = (a == 6'd63) && (b == 6'd63);
                end
            end
        end
    end

    task automatic send_frame(input int code, input bit m, input int f);
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++)
                sb.push_back({24'(f * 4096 + src_of(code, m, r, c)), 6'(r), 6'(c), c == 63});
        @(posedge clk); #1;
        for (int k = 0; k < 4096; k++) begin
            aci = 4'(code); mirror = m;
            i_rgb_data = 24'(f * 4096 + k);
            i_rgb_data_valid = 1'b1;
            @(posedge clk); #1;
            aci = 4'($urandom_range(0, 15));
        end
        i_rgb_data_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done_seen && n < 20000) begin @(negedge clk); n++; end
        if (!done_seen) check("frame_timeout", 0, 1);
        done_seen = 0;
        check("sb_empty", sb.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, o_in_ready, 1);
        check({tag, "_bus"}, {buf_we, buf_waddr, buf_wdata, buf_re, buf_raddr}, 0);
        check({tag, "_out"}, {o_rgb_data_valid, o_rgb_data, a, b, line_flag, frame_done, o_overrun}, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1 reset = 1'b0;

        send_frame(0, 0, 0); wait_done();
        check("a0_first", got_pix[0], 0);
        check("a0_last", got_pix[4095], 4095);

        send_frame(1, 0, 1); wait_done();
        check("a1_00", got_pix[0][11:0], 4032);
        check("a1_01", got_pix[1][11:0], 3968);
        check("a1_6363", got_pix[4095][11:0], 63);

        send_frame(2, 0, 2); wait_done();
        check("a2_00", got_pix[0][11:0], 4095);
        send_frame(3, 0, 3); wait_done();
        check("a3_00", got_pix[0][11:0], 63);
        send_frame(9, 0, 4); wait_done();
        check("a9_01", got_pix[1][11:0], 1);
        check("a9_6363", got_pix[4095][11:0], 4095);

        rnd_ready = 1;
        send_frame(2, 0, 5); wait_done();
        rnd_ready = 0;

        send_frame(1, 0, 6);
        for (int i = 0; i < 20; i++) begin
            i_rgb_data_valid = 1'b1; i_rgb_data = 24'($urandom);
            @(negedge clk);
            check("no_we_drain", buf_we, 0);
            @(posedge clk); #1;
        end
        i_rgb_data_valid = 1'b0;
        wait_done();
        check("overrun_set", o_overrun, 1);
        check("a1b_00", got_pix[0][11:0], 4032);

`ifdef ROT_MIRROR_EN
        send_frame(0, 1, 7); wait_done();
        check("mir_00", got_pix[0][11:0], 63);
        check("mir_5_10", got_pix[5 * 64 + 10][11:0], 373);
`endif

        send_frame(2, 0, 8);
        repeat (100) @(posedge clk);
        #1 reset = 1'b1; i_rgb_data = '0;
        @(posedge clk);
        @(negedge clk);
        sb.delete();
        check_idle_outputs("mid_reset");
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_reset_quiet", {buf_we, buf_re, o_rgb_data_valid}, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rot_frame_sequencer.md
Name: rot_frame_sequencer

Overview:
Frame-level controller that sequences the 64x64 RGB rotation datapath.
- Accepts one input frame as a pixel stream and writes it to an external single-port-per-direction frame buffer in raster order.
- After the frame completes, scans output coordinates in raster order and maps each to a source address for the latched angle.
- Streams rotated pixels out with valid/ready backpressure and a per-row line_flag.

Parameters:
DIM_LOG2, 6, log2 of square image side (DIM = 64); buffer address width = 2*DIM_LOG2
PIX_W, 24, pixel width (B in [7:0], G in [15:8], R in [23:16])

Ports:
axi_clk  in  1  clock
reset  in  1  synchronous active-high reset
aci  in  4  rotation code, sampled at frame start: 0=0°, 1=90° CW, 2=180°, 3=270° CW, 4..15 treated as 0
i_rgb_data_valid  in  1  input pixel valid
i_rgb_data  in  PIX_W  input pixel
o_in_ready  out  1  sequencer accepts input pixel
buf_we  out  1  frame buffer write enable
buf_waddr  out  2*DIM_LOG2  write address
buf_wdata  out  PIX_W  write data
buf_re  out  1  frame buffer read enable
buf_raddr  out  2*DIM_LOG2  read address
buf_rdata  in  PIX_W  read data, valid exactly 1 cycle after buf_re
o_rgb_data_valid  out  1  output pixel valid
o_rgb_data  out  PIX_W  output pixel
i_out_ready  in  1  downstream accepts output pixel
line_flag  out  1  high with the last pixel of each output row (col = DIM-1)
a  out  DIM_LOG2  output row of the current o_rgb_data
b  out  DIM_LOG2  output column of the current o_rgb_data
frame_done  out  1  one-cycle pulse after the last output pixel handshake
o_overrun  out  1  sticky: input valid seen while o_in_ready = 0

Behaviour:
- Reset, synchronous active-high: state=IDLE; all outputs 0 except o_in_ready=1; counters, latched angle and o_overrun cleared. Reset mid-frame abandons the frame; no further buffer writes or reads.
- States:
  - IDLE: o_in_ready=1. First accepted pixel latches aci, is written at address 0, and moves the block to FILL.
  - FILL: each valid pixel is written combinationally in the same cycle: buf_we = valid & o_in_ready, buf_waddr = wcnt, buf_wdata = i_rgb_data. When pixel DIM*DIM-1 is accepted, go to DRAIN and drop o_in_ready the next cycle.
  - DRAIN: output counter (r,c) advances in raster order. Source mapping:
    - 0°: (r,c)
    - 90°: (DIM-1-c, r)
    - 180°: (DIM-1-r, DIM-1-c)
    - 270°: (c, DIM-1-r)
    - buf_raddr = src_row*DIM + src_col; all arithmetic is modulo DIM with no overflow.
  - When the final output pixel is handshaken: pulse frame_done, return to IDLE, o_in_ready=1 on the following cycle.
- Read scheduling: buf_re is issued only when the output skid buffer has room for the read result, counting in-flight reads. Data lands in the skid buffer 1 cycle later, so the first o_rgb_data_valid appears 2 cycles after entering DRAIN.
- Throughput: 1 pixel/cycle when i_out_ready is held high.
- Output handshake: transfer on o_rgb_data_valid & i_out_ready. While valid is low-handshaken (valid high, ready low), o_rgb_data, a, b and line_flag stay stable. Pixels are never lost or duplicated under arbitrary i_out_ready patterns.
- Input while o_in_ready=0: data dropped, no buffer write, o_overrun set until reset.
- aci changes outside IDLE are ignored.

Optional Feature:
ROT_MIRROR_EN
- Defined: adds input port i_mirror (1 bit), latched with aci. When set, a horizontal mirror is applied after rotation (src computed for column DIM-1-c instead of c).
- Undefined: port absent; no mirroring.

Decomposition:
- Package rot_pkg: DIM_LOG2/PIX_W defaults, angle enum (ROT_0, ROT_90, ROT_180, ROT_270), state enum (IDLE, FILL, DRAIN), and the coordinate-to-source mapping function.
- Sub-module rot_skid_buf: 2-entry valid/ready buffer carrying {pixel, a, b, line_flag}; exposes a credit count to the read scheduler.

Test Plan:
- aci=0, input pixel k = k (24-bit), i_out_ready=1: output equals input in order; line_flag on every 64th pixel; frame_done 1 cycle after pixel 4095; first valid 2 cycles after DRAIN entry.
- aci=1, same frame: output (r=0,c=0) = input addr 63*64 = 4032; output (0,1) = 3968; output (63,63) = 63.
- aci=2 and aci=3: output (0,0) = 4095 and 63 respectively; aci=9 behaves as aci=0.
- aci=2 with i_out_ready random at 50% duty: 4096 unique pixels in the correct order, data/a/b stable while stalled, no buf_re beyond skid credit.
- Drive input valid during DRAIN: no buf_we, o_overrun=1, output frame unaffected; then reset mid-DRAIN: all outputs 0, o_in_ready=1 next cycle, o_overrun cleared.
- ROT_MIRROR_EN with aci=0, i_mirror=1: output (0,0) = 63, (5,10) = 5*64+53 = 373.
